// File: rtl/gpio_pad_bank.sv
// N-channel bidirectional GPIO bank: registered pad drive and direction, a 2-flop
// synchroniser with glitch filter on the input side, and sticky edge interrupts.
module gpio_pad_bank #(
    parameter int N           = 8,
    parameter int FILT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [2:0]   wr_sel,
    input  logic [N-1:0] wr_data,
    input  logic [N-1:0] pad_c,
    output logic [N-1:0] pad_i,
    output logic [N-1:0] pad_oen,
    output logic [N-1:0] din,
    output logic [N-1:0] irq_status,
    output logic         irq
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    localparam logic [2:0] SEL_DOUT     = 3'd0;
    localparam logic [2:0] SEL_OEN      = 3'd1;
    localparam logic [2:0] SEL_IRQ_EN   = 3'd2;
    localparam logic [2:0] SEL_IRQ_POL  = 3'd3;
    localparam logic [2:0] SEL_IRQ_CLR  = 3'd4;
    localparam logic [2:0] SEL_DOUT_SET = 3'd5;
    localparam logic [2:0] SEL_DOUT_CLR = 3'd6;

    logic [N-1:0]  dout_q;
    logic [N-1:0]  oen_q;
    logic [N-1:0]  irq_en_q;
    logic [N-1:0]  irq_pol_q;
    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;
    logic [N-1:0]  din_q;
    logic [N-1:0]  status_q;
    logic          irq_q;
    logic [CW-1:0] cnt_q [N];

    logic [N-1:0]  din_upd;
    logic [N-1:0]  set_mask;
    logic [N-1:0]  clr_mask;
    logic [N-1:0]  status_next;

    // Control registers; IRQ_CLR is handled with the status flags, sel 7 is a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q    <= '0;
            oen_q     <= '1;
            irq_en_q  <= '0;
            irq_pol_q <= '1;
        end else if (wr_en) begin
            case (wr_sel)
                SEL_DOUT:     dout_q    <= wr_data;
                SEL_OEN:      oen_q     <= wr_data;
                SEL_IRQ_EN:   irq_en_q  <= wr_data;
                SEL_IRQ_POL:  irq_pol_q <= wr_data;
                SEL_DOUT_SET: dout_q    <= dout_q | wr_data;
                SEL_DOUT_CLR: dout_q    <= dout_q & ~wr_data;
                default: ;
            endcase
        end
    end

    // A channel's filtered value flips only after s2 has disagreed with it for
    // FILT_CYCLES consecutive edges; the new value equals s2 at that edge.
    always_comb begin
        din_upd = '0;
        for (int i = 0; i < N; i++) begin
            din_upd[i] = (sync2_q[i] != din_q[i]) && (cnt_q[i] == CNT_LAST);
        end
        set_mask    = din_upd & irq_en_q & ~(sync2_q ^ irq_pol_q);
        clr_mask    = (wr_en && (wr_sel == SEL_IRQ_CLR)) ? wr_data : '0;
        status_next = (status_q & ~clr_mask) | set_mask;
    end

    // Synchroniser and per-channel glitch filter; the input path ignores direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            din_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= pad_c;
            sync2_q <= sync1_q;
            for (int i = 0; i < N; i++) begin
                if (sync2_q[i] == din_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    din_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Sticky status: a new edge wins over a same-cycle clear of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_next;
            irq_q    <= |status_next;
        end
    end

    assign pad_i      = dout_q;
    assign pad_oen    = oen_q;
    assign din        = din_q;
    assign irq_status = status_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed bench for gpio_pad_bank (N=8, FILT_CYCLES=4): register-write vector
// table plus hand-written sequences for filter latency, glitches and interrupts.
module tb_gpio_pad_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [7:0] wr_data;
    logic [7:0] pad_c;
    logic [7:0] pad_i;
    logic [7:0] pad_oen;
    logic [7:0] din;
    logic [7:0] irq_status;
    logic       irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] data;
        logic [7:0] exp_i;
        logic [7:0] exp_oen;
    } vec_t;

    vec_t vecs [8];

    gpio_pad_bank #(.N(8), .FILT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .pad_c     (pad_c),
        .pad_i     (pad_i),
        .pad_oen   (pad_oen),
        .din       (din),
        .irq_status(irq_status),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic [2:0] sel, input logic [7:0] data);
        wr_en   = en;
        wr_sel  = sel;
        wr_data = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [7:0] data);
        applyStimulus(1'b1, sel, data);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        pad_c = 8'h00;
        applyStimulus(1'b0, 3'd0, 8'h00);
        wait_cycles(2);
        reset = 1'b0;

        checkOutput("reset_pad_oen", pad_oen, 8'hFF);
        checkOutput("reset_pad_i", pad_i, 8'h00);
        checkOutput("reset_din", din, 8'h00);
        checkOutput("reset_status", irq_status, 8'h00);
        checkOutput("reset_irq", irq, 1'b0);

        vecs[0] = '{1'b1, 3'd0, 8'hA5, 8'hA5, 8'hFF};
        vecs[1] = '{1'b1, 3'd1, 8'h0F, 8'hA5, 8'h0F};
        vecs[2] = '{1'b1, 3'd5, 8'h02, 8'hA7, 8'h0F};
        vecs[3] = '{1'b1, 3'd6, 8'h80, 8'h27, 8'h0F};
        vecs[4] = '{1'b1, 3'd7, 8'hFF, 8'h27, 8'h0F};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 8'h27, 8'h0F};
        vecs[6] = '{1'b1, 3'd5, 8'h00, 8'h27, 8'h0F};
        vecs[7] = '{1'b1, 3'd6, 8'h05, 8'h22, 8'h0F};

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].en, vecs[v].sel, vecs[v].data);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_pad_i", v), pad_i, vecs[v].exp_i);
            checkOutput($sformatf("vec%0d_pad_oen", v), pad_oen, vecs[v].exp_oen);
        end
        applyStimulus(1'b0, 3'd0, 8'h00);

        // Steady rise on ch0: din follows exactly five edges after the first sampling edge.
        pad_c = 8'h01;
        wait_cycles(5);
        checkOutput("latency_before", din[0], 1'b0);
        wait_cycles(1);
        checkOutput("latency_at", din[0], 1'b1);
        checkOutput("latency_no_irq", irq, 1'b0);
        pad_c = 8'h00;
        wait_cycles(6);
        checkOutput("fall_back", din[0], 1'b0);

        pad_c = 8'h01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("pulse3_high", din[0], 1'b0);
        end
        pad_c = 8'h00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("pulse3_after", din[0], 1'b0);
        end

        pad_c = 8'h01;
        wait_cycles(3);
        pad_c = 8'h00;
        wait_cycles(1);
        pad_c = 8'h01;
        wait_cycles(3);
        pad_c = 8'h00;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checkOutput("pulse313", din[0], 1'b0);
        end

        pad_c = 8'h01;
        wait_cycles(4);
        pad_c = 8'h00;
        wait_cycles(1);
        checkOutput("pulse4_before", din[0], 1'b0);
        wait_cycles(1);
        checkOutput("pulse4_passes", din[0], 1'b1);
        wait_cycles(6);
        checkOutput("pulse4_falls", din[0], 1'b0);

        // Falling-edge interrupt on ch0 only; ch1 toggles with its enable off.
        do_write(3'd2, 8'h01);
        do_write(3'd3, 8'h00);
        pad_c = 8'h03;
        wait_cycles(6);
        checkOutput("rise_din", din, 8'h03);
        checkOutput("rise_no_status", irq_status, 8'h00);
        checkOutput("rise_no_irq", irq, 1'b0);
        pad_c = 8'h00;
        wait_cycles(5);
        checkOutput("fall_pre_status", irq_status, 8'h00);
        wait_cycles(1);
        checkOutput("fall_din", din, 8'h00);
        checkOutput("fall_status", irq_status, 8'h01);
        checkOutput("fall_irq", irq, 1'b1);
        do_write(3'd4, 8'h01);
        checkOutput("clr0_status", irq_status, 8'h00);
        checkOutput("clr0_irq", irq, 1'b0);

        // Set on ch2 coincides with a clear of the same bit.
        do_write(3'd2, 8'h04);
        do_write(3'd3, 8'hFF);
        pad_c = 8'h04;
        wait_cycles(5);
        applyStimulus(1'b1, 3'd4, 8'h04);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 8'h00);
        checkOutput("setclr_din", din, 8'h04);
        checkOutput("setclr_status", irq_status, 8'h04);
        checkOutput("setclr_irq", irq, 1'b1);
        do_write(3'd2, 8'h00);
        checkOutput("en_off_keeps", irq_status, 8'h04);
        do_write(3'd4, 8'h04);
        checkOutput("clr2_status", irq_status, 8'h00);
        checkOutput("clr2_irq", irq, 1'b0);

        pad_c = 8'h00;
        wait_cycles(7);
        checkOutput("idle_din", din, 8'h00);
        checkOutput("idle_status", irq_status, 8'h00);
        do_write(3'd2, 8'hFF);
        pad_c = 8'hFF;
        wait_cycles(5);
        checkOutput("all_pre_status", irq_status, 8'h00);
        wait_cycles(1);
        checkOutput("all_din", din, 8'hFF);
        checkOutput("all_status", irq_status, 8'hFF);
        checkOutput("all_irq", irq, 1'b1);
        do_write(3'd4, 8'h0F);
        checkOutput("partclr_status", irq_status, 8'hF0);
        checkOutput("partclr_irq", irq, 1'b1);

        // Reset overrides a write presented in the same cycle.
        pad_c = 8'h00;
        reset = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'h5A);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00);
        checkOutput("rst2_pad_i", pad_i, 8'h00);
        checkOutput("rst2_pad_oen", pad_oen, 8'hFF);
        checkOutput("rst2_din", din, 8'h00);
        checkOutput("rst2_status", irq_status, 8'h00);
        checkOutput("rst2_irq", irq, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_pad_bank.md
Name: gpio_pad_bank

Overview:
- Parametrised N-channel bidirectional GPIO bank. Sits between core logic and the per-pin pad cells (data in C, data out I, active-low enable OEN).
- Adds per-channel registered output data and direction, a 2-flop input synchroniser, and a glitch filter.
- Adds edge detection with a programmable polarity, plus sticky interrupt status and a combined IRQ.
- One instance replaces a row of hand-wired pads for a GPIO port.

Parameters:
- N, 8, number of channels (1..32).
- FILT_CYCLES, 4, consecutive cycles a synchronised input must hold a new value before din follows (≥1; 1 = no filtering).
- CW, derived, counter width = clog2(FILT_CYCLES+1); not user-set.

Ports:
- clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  register write strobe, one write per asserted cycle.
- wr_sel  input  3  target: 0 DOUT, 1 OEN, 2 IRQ_EN, 3 IRQ_POL, 4 IRQ_CLR, 5 DOUT_SET, 6 DOUT_CLR, 7 ignored.
- wr_data  input  N  write data, one bit per channel.
- pad_c  input  N  raw pad input (C of each pad cell); asynchronous.
- pad_i  output  N  pad drive value (to I).
- pad_oen  output  N  pad output enable, active low (to OEN); 1 = tri-state.
- din  output  N  synchronised, filtered input value.
- irq_status  output  N  sticky per-channel edge flags.
- irq  output  1  OR-reduction of irq_status.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, reset).
- Reset values (applied at the clock edge where reset=1; outputs are direct register outputs):
  - pad_i=0, pad_oen=all 1s (all inputs).
  - din=0, irq_status=0, irq=0.
  - Internal: IRQ_EN=0, IRQ_POL=all 1s, sync flops=0, filter counters=0.
- Reset mid-operation: filter progress and pending writes are discarded. Reset has priority over wr_en.
- Writes, effective at the edge where wr_en=1:
  - DOUT: dout<=wr_data. OEN: oen<=wr_data. IRQ_EN and IRQ_POL load directly.
  - DOUT_SET: dout|=wr_data. DOUT_CLR: dout&=~wr_data.
  - IRQ_CLR: write-1-to-clear on irq_status.
  - sel 7: no state change.
  - pad_i and pad_oen show the new value immediately after that edge (latency 1).
- Input path, per channel i:
  - s1<=pad_c[i]; s2<=s1.
  - If s2==din[i]: cnt<=0.
  - Else if cnt==FILT_CYCLES-1: din[i]<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
- Latency: if pad_c changes before edge k and stays stable, din changes at edge k+1+FILT_CYCLES. FILT_CYCLES=1 gives 2 cycles.
- Glitch rejection:
  - A level lasting fewer than FILT_CYCLES cycles at s2 never reaches din; the counter restarts from 0.
  - Values toggling back to din mid-count clear the counter.
- The input path is independent of pad_oen. A driven pin reads back its own drive through the pad, with the same latency.
- Edge detect: at the edge where din[i] updates, irq_status[i] is set if both hold:
  - IRQ_EN[i]=1;
  - the new value equals IRQ_POL[i] (POL=1: rising edge; POL=0: falling edge).
- Status rules:
  - Set has priority over an IRQ_CLR of the same bit in the same cycle.
  - Clearing IRQ_EN does not clear existing status bits.
  - irq is registered as |irq_status_next, so it tracks irq_status in the same cycle.
- Wrap and saturation: cnt never exceeds FILT_CYCLES-1, so there is no wrap.

Test Plan:
1. Reset, then sample outputs → pad_oen=8'hFF, pad_i=0, din=0, irq_status=0, irq=0. Re-assert reset with writes pending → all return to these values.
2. DOUT 8'hA5, OEN 8'h0F, DOUT_SET 8'h02, then DOUT_CLR 8'h80 → pad_i=A5, A7, 27 on consecutive cycles; pad_oen=0F. Write with wr_sel=7 → nothing changes.
3. FILT_CYCLES=4: pad_c[0] goes 0→1 before edge k and holds → din[0]=1 exactly after edge k+5. A 3-cycle high pulse → din[0] stays 0. Pulses of 3 high, 1 low, 3 high → din stays 0.
4. IRQ_EN=01, IRQ_POL=00 (falling): a rising edge on ch0 → no status; a later falling edge → irq_status[0]=1 and irq=1 in the din update cycle. Ch1 edges with enable 0 → never flagged.
5. Edge sets irq_status[2] in the same cycle as IRQ_CLR 8'h04 → status stays 1. IRQ_CLR 8'h04 next cycle → status 0, irq 0.
6. Simultaneous rising edges on all 8 channels, IRQ_EN=FF, POL=FF → irq_status=FF in one cycle. Clear 8'h0F → F0, irq stays 1.
